// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and its neighbours: entry record,
// completion/commit buses and the default geometry.
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 64;
  localparam int DATA_W    = 32;
  localparam int LOGIC_W   = 8;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic [LOGIC_W-1:0] dest_logic;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  data;
  } rob_entry_t;

  typedef struct packed {
    logic               en;
    logic [LOGIC_W-1:0] dest_logic;
    logic [TAG_W-1:0]   dest_phys;
    logic [DATA_W-1:0]  data;
  } complete_info_t;

  typedef struct packed {
    logic               en;
    logic [LOGIC_W-1:0] dest_logic;
    logic [DATA_W-1:0]  data;
  } commit_info_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / commit bundle between the pipeline and the reorder buffer.
interface reorder_buffer_if;
  import rob_pkg::*;

  // dispatch_en allocates only on an edge where dispatch_ready is also 1; complete
  // and commit are fire-and-forget strobes with no backpressure.
  logic               flash;
  logic               dispatch_en;
  logic [LOGIC_W-1:0] dispatch_logic;
  logic               dispatch_ready;
  logic [TAG_W-1:0]   dispatch_tag;
  complete_info_t     complete;
  commit_info_t       commit;
  logic               overflow;

  modport master (
    output flash, dispatch_en, dispatch_logic, complete,
    input  dispatch_ready, dispatch_tag, commit, overflow
  );

  modport slave (
    input  flash, dispatch_en, dispatch_logic, complete,
    output dispatch_ready, dispatch_tag, commit, overflow
  );
endinterface

// File: rtl/reorder_buffer_entry_array.sv
// Entry storage: write port at tail, tag-matched completion port, read/clear port at head.
module rob_entry_array
  import rob_pkg::*;
#(
  parameter  int DEPTH = ROB_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [LOGIC_W-1:0] wr_logic,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               upd_en,
  input  logic [TAG_W-1:0]   upd_tag,
  input  logic [DATA_W-1:0]  upd_data,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_clr,
  output logic               rd_valid,
  output logic               rd_done,
  output logic [LOGIC_W-1:0] rd_logic,
  output logic [DATA_W-1:0]  rd_data
);
  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [IDX_W-1:0] upd_idx;

  assign upd_idx = upd_tag[IDX_W-1:0];

  // Write, update and clear never hit the same slot: the tail slot is free,
  // and only a not-yet-done entry accepts a completion.
  always_comb begin
    entries_d = entries_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end else begin
      if (rd_clr) begin
        entries_d[rd_idx].valid = 1'b0;
        entries_d[rd_idx].done  = 1'b0;
      end
      if (upd_en && entries_q[upd_idx].valid && !entries_q[upd_idx].done &&
          entries_q[upd_idx].tag == upd_tag) begin
        entries_d[upd_idx].done = 1'b1;
        entries_d[upd_idx].data = upd_data;
      end
      if (wr_en) begin
        entries_d[wr_idx] = '{valid: 1'b1, done: 1'b0, dest_logic: wr_logic,
                              tag: wr_tag, data: '0};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  assign rd_valid = entries_q[rd_idx].valid;
  assign rd_done  = entries_q[rd_idx].done;
  assign rd_logic = entries_q[rd_idx].dest_logic;
  assign rd_data  = entries_q[rd_idx].data;
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at dispatch, records completions,
// retires the oldest finished entry each cycle as CommitInfo.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter  int DEPTH = ROB_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  reorder_buffer_if.slave  bus
);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]     count_q, count_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  commit_info_t       commit_q, commit_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;
  logic               do_dispatch, do_commit;
  logic               head_valid, head_done;
  logic [LOGIC_W-1:0] head_logic;
  logic [DATA_W-1:0]  head_data;
  logic               unused_dest_logic;

  // The completing unit's logical register is informational only.
  assign unused_dest_logic = ^bus.complete.dest_logic;

  rob_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (bus.flash),
    .wr_en    (do_dispatch),
    .wr_idx   (tail_q),
    .wr_logic (bus.dispatch_logic),
    .wr_tag   (tag_q),
    .upd_en   (bus.complete.en),
    .upd_tag  (bus.complete.dest_phys),
    .upd_data (bus.complete.data),
    .rd_idx   (head_q),
    .rd_clr   (do_commit),
    .rd_valid (head_valid),
    .rd_done  (head_done),
    .rd_logic (head_logic),
    .rd_data  (head_data)
  );

  always_comb begin
    do_dispatch = !bus.flash && bus.dispatch_en && ready_q;
    do_commit   = !bus.flash && head_valid && head_done;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    tag_d       = tag_q;
    commit_d    = commit_q;
    commit_d.en = do_commit;
    overflow_d  = overflow_q | (!bus.flash && bus.dispatch_en && !ready_q);
    if (do_commit) begin
      commit_d.dest_logic = head_logic;
      commit_d.data       = head_data;
    end
    if (bus.flash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      tag_d   = '0;
    end else begin
      if (do_dispatch) begin
        tail_d = tail_q + 1'b1;
        tag_d  = tag_q + 64'd1;
      end
      if (do_commit) head_d = head_q + 1'b1;
      // Full and empty are told apart by count alone; head==tail is ambiguous.
      count_d = count_q + {{IDX_W{1'b0}}, do_dispatch} - {{IDX_W{1'b0}}, do_commit};
    end
    ready_d = (count_d != FULL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      tag_q      <= '0;
      commit_q   <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      tag_q      <= tag_d;
      commit_q   <= commit_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.dispatch_ready = ready_q;
  assign bus.dispatch_tag   = tag_q;
  assign bus.commit         = commit_q;
  assign bus.overflow       = overflow_q;
endmodule
